instruction_memory_loadable: RTL and testbench

Parametrised, writable instruction memory for the single-cycle MIPS core and its successors. A load FSM accepts a program image as a word stream over a valid/ready handshake. It writes each word to consecutive addresses from a base, and a per-word valid vector guarantees that unwritten locations read as NOP. The fetch port supports combinational reads for the single-cycle core, or registered one-cycle-latency reads, selected by parameter.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_load_fsm.sv | 77 +++++++
 rtl/instruction_memory_loadable.sv | 88 ++++++++
 tb/tb_instruction_memory_loadable.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The MIPS field values let benches build recognisable program words.
package imem_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE,
        IMEM_LOAD,
        IMEM_DONE
    } imem_state_t;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;

endpackage

// File: rtl/imem_load_fsm.sv
// Load sequencer: validates a load request, then streams words into
// consecutive addresses over a valid/ready handshake.
module imem_load_fsm
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr
);

    imem_state_t           state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH+1:0] load_end;
    logic                  bad_request;

    // Two extra bits so base+len can never wrap back into range.
    assign load_end    = {2'b00, load_base} + {1'b0, load_len};
    assign bad_request = (load_len == '0) ||
                         (load_end > (ADDR_WIDTH+2)'(DEPTH));

    assign loading  = (state == IMEM_LOAD);
    assign wr_ready = (state == IMEM_LOAD);
    assign we       = (state == IMEM_LOAD) && wr_valid;
    assign waddr    = ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IMEM_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            case (state)
                IMEM_IDLE: begin
                    if (load_start) begin
                        if (bad_request) begin
                            load_error <= 1'b1;
                        end else begin
                            state <= IMEM_LOAD;
                            ptr   <= load_base;
                            cnt   <= load_len;
                        end
                    end
                end
                IMEM_LOAD: begin
                    if (wr_valid) begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == (ADDR_WIDTH+1)'(1)) begin
                            state     <= IMEM_DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                IMEM_DONE: state <= IMEM_IDLE;
                default:   state <= IMEM_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Writable instruction memory: word array plus per-word valid mask so
// unwritten locations fetch as NOP; fetch is combinational or registered.
module instruction_memory_loadable
    import imem_pkg::*;
#(
    parameter int                     ADDR_WIDTH = 8,
    parameter int                     DATA_WIDTH = 32,
    parameter int                     DEPTH      = 256,
    parameter int                     SYNC_READ  = 0,
    parameter logic [DATA_WIDTH-1:0]  NOP_WORD   = DATA_WIDTH'(IMEM_NOP)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  rd_valid,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_error
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      word_valid;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] fetch_word;

    imem_load_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .loading    (loading),
        .load_done  (load_done),
        .load_error (load_error),
        .we         (we),
        .waddr      (waddr)
    );

    // The array itself is never reset; word_valid hides stale contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_valid <= '0;
        end else if (we) begin
            word_valid[waddr] <= 1'b1;
        end
    end

    assign in_range   = ({1'b0, A} < (ADDR_WIDTH+1)'(DEPTH));
    assign fetch_word = (!loading && in_range && word_valid[A]) ? mem[A] : NOP_WORD;

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    RD       <= NOP_WORD;
                    rd_valid <= 1'b0;
                end else begin
                    RD       <= fetch_word;
                    rd_valid <= !loading;
                end
            end
        end else begin : g_comb_read
            assign RD       = fetch_word;
            assign rd_valid = !loading;
        end
    endgenerate

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench driving a combinational-read and a registered-read instance
// with the same load/fetch stimulus and checking both against literal values.
module tb_instruction_memory_loadable;
    import imem_pkg::*;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 256;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] A;
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic [ADDR_WIDTH:0]   load_len;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0] comb_rd, sync_rd;
    logic comb_rd_valid, comb_wr_ready, comb_loading, comb_done, comb_error;
    logic sync_rd_valid, sync_wr_ready, sync_loading, sync_done, sync_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [5] = '{32'h20010003, 32'h20020009, 32'h00221020,
                              32'h00221824, 32'h00222025};

    always #5 clk = ~clk;

    instruction_memory_loadable #(
        .ADDR_WIDTH (ADDR_WIDTH), .DATA_WIDTH (DATA_WIDTH), .DEPTH (DEPTH),
        .SYNC_READ (0), .NOP_WORD (NOP)
    ) u_comb (
        .clk (clk), .reset (reset), .A (A), .RD (comb_rd), .rd_valid (comb_rd_valid),
        .load_start (load_start), .load_base (load_base), .load_len (load_len),
        .wr_valid (wr_valid), .wr_data (wr_data), .wr_ready (comb_wr_ready),
        .loading (comb_loading), .load_done (comb_done), .load_error (comb_error)
    );

    instruction_memory_loadable #(
        .ADDR_WIDTH (ADDR_WIDTH), .DATA_WIDTH (DATA_WIDTH), .DEPTH (DEPTH),
        .SYNC_READ (1), .NOP_WORD (NOP)
    ) u_sync (
        .clk (clk), .reset (reset), .A (A), .RD (sync_rd), .rd_valid (sync_rd_valid),
        .load_start (load_start), .load_base (load_base), .load_len (load_len),
        .wr_valid (wr_valid), .wr_data (wr_data), .wr_ready (sync_wr_ready),
        .loading (sync_loading), .load_done (sync_done), .load_error (sync_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [ADDR_WIDTH-1:0] base,
                                 input logic [ADDR_WIDTH:0] len, input logic valid,
                                 input logic [DATA_WIDTH-1:0] data);
        load_start = start;
        load_base  = base;
        load_len   = len;
        wr_valid   = valid;
        wr_data    = data;
    endtask

    initial begin
        logic [7:0] valid_pat;
        int         k;

        reset = 1'b1;
        A     = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0);

        // Reset values while reset is held.
        #12;
        checkOutput("rst_loading", comb_loading, 1'b0);
        checkOutput("rst_wr_ready", comb_wr_ready, 1'b0);
        checkOutput("rst_done", comb_done, 1'b0);
        checkOutput("rst_error", comb_error, 1'b0);
        checkOutput("rst_sync_rd", sync_rd, NOP);
        checkOutput("rst_sync_rd_valid", sync_rd_valid, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("post_rst_sync_rd_valid", sync_rd_valid, 1'b0);

        $display("[TB] fetch with nothing loaded");
        for (int i = 0; i < 5; i++) begin
            A = 8'(i);
            #1;
            checkOutput("empty_comb_rd", comb_rd, NOP);
            checkOutput("empty_comb_rd_valid", comb_rd_valid, 1'b1);
            tick();
            checkOutput("empty_sync_rd", sync_rd, NOP);
            checkOutput("empty_sync_rd_valid", sync_rd_valid, 1'b1);
        end

        $display("[TB] back-to-back load base=0 len=5");
        A = 8'd2;
        applyStimulus(1'b1, 8'd0, 9'd5, 1'b0, '0);
        tick();
        load_start = 1'b0;
        checkOutput("ld_loading", comb_loading, 1'b1);
        checkOutput("ld_wr_ready", comb_wr_ready, 1'b1);
        checkOutput("ld_comb_rd_valid", comb_rd_valid, 1'b0);
        checkOutput("ld_sync_rd_valid_lag", sync_rd_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = prog[i];
            tick();
            if (i == 0) checkOutput("ld_sync_rd_valid_drop", sync_rd_valid, 1'b0);
            if (i == 3) checkOutput("ld_no_early_done", comb_done, 1'b0);
        end
        wr_valid = 1'b0;
        checkOutput("ld_done_pulse", comb_done, 1'b1);
        checkOutput("ld_done_loading", comb_loading, 1'b0);
        checkOutput("ld_done_wr_ready", comb_wr_ready, 1'b0);
        checkOutput("ld_done_comb_rd", comb_rd, prog[2]);
        checkOutput("ld_done_sync_rd", sync_rd, NOP);
        checkOutput("ld_done_sync_rd_valid", sync_rd_valid, 1'b0);
        tick();
        checkOutput("ld_done_cleared", comb_done, 1'b0);
        checkOutput("ld_after_sync_rd", sync_rd, prog[2]);
        checkOutput("ld_after_sync_rd_valid", sync_rd_valid, 1'b1);
        A = 8'd5;
        #1;
        checkOutput("ld_unwritten_comb", comb_rd, NOP);
        tick();
        checkOutput("ld_unwritten_sync", sync_rd, NOP);

        $display("[TB] stalled load with wr_valid gaps");
        valid_pat = 8'b1101_1001;
        k = 0;
        applyStimulus(1'b1, 8'd0, 9'd5, 1'b0, '0);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_valid = valid_pat[i];
            wr_data  = valid_pat[i] ? prog[k] : 32'hDEAD_BEEF;
            if (valid_pat[i]) k++;
            #1;
            checkOutput("stall_wr_ready", comb_wr_ready, 1'b1);
            tick();
        end
        wr_valid = 1'b0;
        checkOutput("stall_done", comb_done, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            A = 8'(i);
            #1;
            checkOutput("stall_contents", comb_rd, prog[i]);
        end

        $display("[TB] rejected load requests");
        applyStimulus(1'b1, 8'd250, 9'd7, 1'b0, '0);
        tick();
        load_start = 1'b0;
        checkOutput("oob_error", comb_error, 1'b1);
        checkOutput("oob_loading", comb_loading, 1'b0);
        checkOutput("oob_wr_ready", comb_wr_ready, 1'b0);
        tick();
        checkOutput("oob_error_cleared", comb_error, 1'b0);
        checkOutput("oob_still_idle", comb_loading, 1'b0);
        applyStimulus(1'b1, 8'd0, 9'd0, 1'b0, '0);
        tick();
        load_start = 1'b0;
        checkOutput("zero_len_error", comb_error, 1'b1);
        checkOutput("zero_len_loading", comb_loading, 1'b0);
        tick();

        $display("[TB] boundary load base=250 len=6");
        A = 8'd255;
        tick();
        checkOutput("top_unwritten_sync", sync_rd, NOP);
        applyStimulus(1'b1, 8'd250, 9'd6, 1'b0, '0);
        tick();
        load_start = 1'b0;
        checkOutput("edge_no_error", comb_error, 1'b0);
        checkOutput("edge_loading", comb_loading, 1'b1);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = prog[i % 5];
            tick();
        end
        wr_valid = 1'b0;
        checkOutput("edge_done", comb_done, 1'b1);
        checkOutput("edge_top_word", comb_rd, prog[0]);

        $display("[TB] asynchronous reset mid-load");
        tick();
        A = 8'd0;
        applyStimulus(1'b1, 8'd0, 9'd5, 1'b0, '0);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = prog[i];
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_loading", comb_loading, 1'b0);
        checkOutput("arst_wr_ready", comb_wr_ready, 1'b0);
        checkOutput("arst_comb_rd", comb_rd, NOP);
        checkOutput("arst_comb_rd_valid", comb_rd_valid, 1'b1);
        checkOutput("arst_sync_rd", sync_rd, NOP);
        checkOutput("arst_sync_rd_valid", sync_rd_valid, 1'b0);
        wr_valid = 1'b0;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 8'd0, 9'd5, 1'b0, '0);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = prog[i];
            tick();
        end
        wr_valid = 1'b0;
        checkOutput("reload_done", comb_done, 1'b1);
        tick();
        A = 8'd2;
        #1;
        checkOutput("reload_contents", comb_rd, prog[2]);

        $display("[TB] registered fetch latency");
        A = 8'd4;
        tick();
        for (int i = 0; i < 5; i++) begin
            A = 8'(i);
            #1;
            checkOutput("sync_before_edge", sync_rd, prog[(i == 0) ? 4 : i - 1]);
            tick();
            checkOutput("sync_after_edge", sync_rd, prog[i]);
        end
        A = 8'd255;
        tick();
        checkOutput("sync_top_cleared", sync_rd, NOP);
        checkOutput("sync_top_rd_valid", sync_rd_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
